// File: rtl/sram_dw_pkg.sv
// Shared types and helpers for the banked 1w1r SRAM with write buffer.
package sram_dw_pkg;

  localparam int DEF_ABITS      = 15;
  localparam int DEF_DBITS      = 64;
  localparam int DEF_BANK_ABITS = 13;
  localparam int DEF_WBUF_DEPTH = 4;

  typedef struct packed {
    logic [DEF_ABITS-1:0] addr;
    logic [DEF_DBITS-1:0] data;
    logic [DEF_DBITS-1:0] mask;
  } wbuf_entry_t;

  function automatic int nbanks(input int abits, input int bank_abits);
    return 1 << (abits - bank_abits);
  endfunction

  // Caller truncates to the bank-index width; addr is zero-extended.
  function automatic int unsigned bank_idx(input logic [31:0] addr, input int bank_abits);
    return int'(addr >> bank_abits);
  endfunction

endpackage

// File: rtl/sram_dw_bank.sv
// Single-port SRAM bank with bit-granular write mask, 1-cycle read.
module sram_dw_bank #(
  parameter int AW = 13,
  parameter int DW = 64
) (
  input  logic          gclk,
  input  logic          ce,
  input  logic          we,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  input  logic [DW-1:0] wem,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  // q only moves on reads, so it holds across writes and idle cycles.
  always_ff @(posedge gclk) begin
    if (ce) begin
      if (we) mem[a] <= (mem[a] & ~wem) | (d & wem);
      else    q      <= mem[a];
    end
  end

endmodule

// File: rtl/sram_dw_wbuf.sv
// In-order write buffer with oldest-to-newest forwarding merge on a lookup address.
module sram_dw_wbuf
  import sram_dw_pkg::*;
#(
  parameter int AW    = DEF_ABITS,
  parameter int DW    = DEF_DBITS,
  parameter int DEPTH = DEF_WBUF_DEPTH
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          enq,
  input  logic [AW-1:0] enq_addr,
  input  logic [DW-1:0] enq_data,
  input  logic [DW-1:0] enq_mask,
  input  logic          deq,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [DW-1:0] head_mask,
  output logic [3:0]    count,
  output logic          empty,
  input  logic [AW-1:0] lkp_addr,
  output logic [DW-1:0] fwd_data,
  output logic [DW-1:0] fwd_mask
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
  } entry_t;

  entry_t        ent_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [3:0]    cnt_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge gclk) begin
    if (enq) ent_q[tail_q] <= '{addr: enq_addr, data: enq_data, mask: enq_mask};
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq) tail_q <= nxt(tail_q);
      if (deq) head_q <= nxt(head_q);
      cnt_q <= cnt_q + 4'(enq) - 4'(deq);
    end
  end

  assign head_addr = ent_q[head_q].addr;
  assign head_data = ent_q[head_q].data;
  assign head_mask = ent_q[head_q].mask;
  assign count     = cnt_q;
  assign empty     = (cnt_q == 4'd0);

  // Walk from head so later entries overwrite earlier ones bit by bit.
  always_comb begin
    logic [PW:0]   s;
    logic [PW-1:0] idx;
    fwd_data = '0;
    fwd_mask = '0;
    s        = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s = {1'b0, head_q} + (PW+1)'(i);
      if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
      idx = s[PW-1:0];
      if (4'(i) < cnt_q && ent_q[idx].addr == lkp_addr) begin
        fwd_mask = fwd_mask | ent_q[idx].mask;
        fwd_data = (fwd_data & ~ent_q[idx].mask) | (ent_q[idx].data & ent_q[idx].mask);
      end
    end
  end

endmodule

// File: rtl/sram_dw_banked_wbuf.sv
// 1w1r memory on single-port banks: reads win bank conflicts, writes park in an
// in-order buffer, and reads forward buffered data.
module sram_dw_banked_wbuf
  import sram_dw_pkg::*;
#(
  parameter int ABITS      = DEF_ABITS,
  parameter int DBITS      = DEF_DBITS,
  parameter int BANK_ABITS = DEF_BANK_ABITS,
  parameter int WBUF_DEPTH = DEF_WBUF_DEPTH
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CE0,
  input  logic [ABITS-1:0] A0,
  input  logic [DBITS-1:0] D0,
  input  logic             WE0,
  input  logic [DBITS-1:0] WEM0,
  output logic             WRDY0,
  input  logic             CE1,
  input  logic [ABITS-1:0] A1,
  output logic [DBITS-1:0] Q1
);

  localparam int NBANKS = nbanks(ABITS, BANK_ABITS);
  localparam int BW     = (ABITS > BANK_ABITS) ? ABITS - BANK_ABITS : 1;

  logic                          rd, wr_in, empty, cand_vld, issue, enq, deq;
  logic [BW-1:0]                 rb, wb, rb_q;
  logic [ABITS-1:0]              head_addr, cand_addr;
  logic [DBITS-1:0]              head_data, head_mask, cand_data, cand_mask;
  logic [DBITS-1:0]              fwd_data, fwd_mask, fd_q, fm_q;
  logic [3:0]                    count;
  logic                          rvld_q;
  logic [NBANKS-1:0][DBITS-1:0]  b_q;

  assign WRDY0 = (count < 4'(WBUF_DEPTH));
  assign wr_in = CE0 & WE0 & WRDY0;
  assign rd    = CE1;
  assign rb    = BW'(bank_idx(32'(A1), BANK_ABITS));

  // Buffered writes drain before any new write so retirement stays in order.
  assign cand_addr = empty ? A0   : head_addr;
  assign cand_data = empty ? D0   : head_data;
  assign cand_mask = empty ? WEM0 : head_mask;
  assign cand_vld  = !empty | wr_in;
  assign wb        = BW'(bank_idx(32'(cand_addr), BANK_ABITS));
  assign issue     = cand_vld & (!rd | (wb != rb));
  assign deq       = !empty & issue;
  assign enq       = wr_in & !(empty & issue);

  sram_dw_wbuf #(.AW(ABITS), .DW(DBITS), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .gclk      (CLK),
    .grst_n    (RSTN),
    .enq       (enq),
    .enq_addr  (A0),
    .enq_data  (D0),
    .enq_mask  (WEM0),
    .deq       (deq),
    .head_addr (head_addr),
    .head_data (head_data),
    .head_mask (head_mask),
    .count     (count),
    .empty     (empty),
    .lkp_addr  (A1),
    .fwd_data  (fwd_data),
    .fwd_mask  (fwd_mask)
  );

  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    logic                  ce, we;
    logic [BANK_ABITS-1:0] a;
    logic [DBITS-1:0]      d, wem;

    always_comb begin
      ce  = 1'b0;
      we  = 1'b0;
      a   = '0;
      d   = '0;
      wem = '0;
      if (rd && rb == BW'(g)) begin
        ce = 1'b1;
        a  = A1[BANK_ABITS-1:0];
      end else if (issue && wb == BW'(g)) begin
        ce  = 1'b1;
        we  = 1'b1;
        a   = cand_addr[BANK_ABITS-1:0];
        d   = cand_data;
        wem = cand_mask;
      end
    end

    sram_dw_bank #(.AW(BANK_ABITS), .DW(DBITS)) u_bank (
      .gclk (CLK),
      .ce   (ce),
      .we   (we),
      .a    (a),
      .d    (d),
      .wem  (wem),
      .q    (b_q[g])
    );
  end

  // Bank select and forwarding state only move on a read, keeping Q1 stable.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rvld_q <= 1'b0;
      rb_q   <= '0;
      fd_q   <= '0;
      fm_q   <= '0;
    end else if (rd) begin
      rvld_q <= 1'b1;
      rb_q   <= rb;
      fd_q   <= fwd_data;
      fm_q   <= fwd_mask;
    end
  end

  assign Q1 = rvld_q ? ((b_q[rb_q] & ~fm_q) | (fd_q & fm_q)) : '0;

  always_ff @(posedge CLK) begin
    if (RSTN && CE0 && WE0) assert (WRDY0);
  end

endmodule

// File: tb/tb_sram_dw_banked_wbuf.sv
// Scoreboarded bench: a flat 1w1r memory model predicts every read of the banked DUT.
module tb_sram_dw_banked_wbuf;

  logic        CLK, RSTN, CE0, WE0, CE1, WRDY0;
  logic [14:0] A0, A1;
  logic [63:0] D0, WEM0, Q1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mem_m [int];
  logic [63:0] exp_q [$];
  string       tag_q [$];

  localparam logic [63:0] FULL = 64'hFFFF_FFFF_FFFF_FFFF;

  sram_dw_banked_wbuf #(.ABITS(15), .DBITS(64), .BANK_ABITS(13), .WBUF_DEPTH(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
    .WRDY0(WRDY0), .CE1(CE1), .A1(A1), .Q1(Q1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] rd_model(input logic [14:0] a);
    return mem_m.exists(int'(a)) ? mem_m[int'(a)] : 64'h0;
  endfunction

  // One clock of stimulus: read expectation is captured before the same-cycle write lands.
  task automatic cyc(input logic we, input logic [14:0] wa, input logic [63:0] wd,
                     input logic [63:0] wm, input logic re, input logic [14:0] ra,
                     input string tag);
    logic [63:0] e;
    string       t;
    CE0 = we; WE0 = we; A0 = wa; D0 = wd; WEM0 = wm;
    CE1 = re; A1 = ra;
    if (re) begin
      exp_q.push_back(rd_model(ra));
      tag_q.push_back(tag);
    end
    if (we) begin
      if (!WRDY0) begin
        n_tests++; n_fail++;
        $display("FAIL %s: write presented with WRDY0=%b, expected 1", tag, WRDY0);
      end else begin
        mem_m[int'(wa)] = (rd_model(wa) & ~wm) | (wd & wm);
      end
    end
    @(posedge CLK); #1;
    CE0 = 1'b0; WE0 = 1'b0; CE1 = 1'b0;
    if (re) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_tests++;
      if (Q1 !== e) begin
        n_fail++;
        $display("FAIL %s: Q1=%h expected %h", t, Q1, e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, 1'b0, '0, "idle");
  endtask

  task automatic chk_cnt(input logic [3:0] e, input string tag);
    n_tests++;
    if (dut.u_wbuf.count !== e) begin
      n_fail++;
      $display("FAIL %s: count=%0d expected %0d", tag, dut.u_wbuf.count, e);
    end
  endtask

  task automatic chk_rdy(input logic e, input string tag);
    n_tests++;
    if (WRDY0 !== e) begin
      n_fail++;
      $display("FAIL %s: WRDY0=%b expected %b", tag, WRDY0, e);
    end
  endtask

  task automatic chk_q(input logic [63:0] e, input string tag);
    n_tests++;
    if (Q1 !== e) begin
      n_fail++;
      $display("FAIL %s: Q1=%h expected %h", tag, Q1, e);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0; CE0 = 0; WE0 = 0; CE1 = 0; A0 = '0; A1 = '0; D0 = '0; WEM0 = '0;
    #3;
    chk_rdy(1'b1, "reset_wrdy");
    chk_q(64'h0, "reset_q1");
    #9 RSTN = 1'b1;
    @(posedge CLK); #1;
    chk_cnt(4'd0, "reset_count");
    chk_q(64'h0, "reset_q1_after");
  endtask

  task automatic test_diff_bank();
    cyc(1'b1, 15'h2010, 64'hBEEF, FULL, 1'b0, '0, "db_init");
    cyc(1'b1, 15'h0010, 64'hAAAA_AAAA_AAAA_AAAA, FULL, 1'b1, 15'h2010, "db_read_other_bank");
    chk_cnt(4'd0, "db_direct_count");
    cyc(1'b0, '0, '0, '0, 1'b1, 15'h0010, "db_read_back");
    idle(2);
    chk_q(64'hAAAA_AAAA_AAAA_AAAA, "db_q1_hold");
  endtask

  task automatic test_conflict_fwd();
    cyc(1'b1, 15'h0005, 64'h0, FULL, 1'b0, '0, "cf_init5");
    cyc(1'b1, 15'h0007, 64'h77, FULL, 1'b0, '0, "cf_init7");
    cyc(1'b1, 15'h0005, 64'h1234, FULL, 1'b1, 15'h0007, "cf_conflict_read");
    chk_cnt(4'd1, "cf_buffered");
    cyc(1'b0, '0, '0, '0, 1'b1, 15'h0005, "cf_forward");
    chk_cnt(4'd1, "cf_still_buffered");
    idle(1);
    chk_cnt(4'd0, "cf_drained");
    cyc(1'b0, '0, '0, '0, 1'b1, 15'h0005, "cf_from_bank");
  endtask

  task automatic test_partial_mask();
    cyc(1'b1, 15'h0010, 64'hFFFF_0000, FULL, 1'b0, '0, "pm_init");
    cyc(1'b1, 15'h0020, 64'h2020, FULL, 1'b0, '0, "pm_init20");
    cyc(1'b1, 15'h0010, 64'h11, 64'h0000_00FF, 1'b1, 15'h0020, "pm_w1");
    cyc(1'b1, 15'h0010, 64'h2222, 64'h0000_FF0F, 1'b1, 15'h0010, "pm_w2_read_mid");
    chk_cnt(4'd2, "pm_two_buffered");
    cyc(1'b0, '0, '0, '0, 1'b1, 15'h0010, "pm_merge");
    n_tests++;
    if (Q1 !== 64'hFFFF_2212) begin
      n_fail++;
      $display("FAIL pm_merge_const: Q1=%h expected %h", Q1, 64'hFFFF_2212);
    end
    idle(2);
    cyc(1'b0, '0, '0, '0, 1'b1, 15'h0010, "pm_after_drain");
  endtask

  task automatic test_full();
    logic [14:0] wa [4] = '{15'h0040, 15'h0041, 15'h0040, 15'h0041};
    cyc(1'b1, 15'h0030, 64'h3030_3030, FULL, 1'b0, '0, "fb_init");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, wa[i], 64'hC0DE_0000 + 64'(i), FULL, 1'b1, 15'h0030, "fb_hold_read");
      chk_cnt(4'(i + 1), "fb_fill");
    end
    chk_rdy(1'b0, "fb_full_wrdy");
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk_cnt(4'(3 - i), "fb_drain");
    end
    chk_rdy(1'b1, "fb_wrdy_back");
    cyc(1'b0, '0, '0, '0, 1'b1, 15'h0040, "fb_read40");
    cyc(1'b0, '0, '0, '0, 1'b1, 15'h0041, "fb_read41");
  endtask

  task automatic test_async_reset();
    logic [63:0] old [3];
    for (int i = 0; i < 3; i++) begin
      old[i] = 64'h5000 + 64'(i);
      cyc(1'b1, 15'h0050 + 15'(i), old[i], FULL, 1'b0, '0, "ar_init");
    end
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 15'h0050 + 15'(i), 64'hDEAD_0000 + 64'(i), FULL, 1'b1, 15'h0030, "ar_buffer");
    chk_cnt(4'd3, "ar_three_buffered");
    for (int i = 0; i < 3; i++) mem_m[int'(15'h0050) + i] = old[i];
    CE1 = 1'b1; A1 = 15'h0030;
    #2 RSTN = 1'b0;
    #1;
    chk_rdy(1'b1, "ar_wrdy_now");
    chk_q(64'h0, "ar_q1_now");
    chk_cnt(4'd0, "ar_count_now");
    @(posedge CLK); #1;
    chk_q(64'h0, "ar_q1_in_reset");
    CE1 = 1'b0;
    #2 RSTN = 1'b1;
    @(posedge CLK); #1;
    chk_q(64'h0, "ar_q1_no_read");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, '0, '0, '0, 1'b1, 15'h0050 + 15'(i), "ar_lost_write");
  endtask

  task automatic test_same_addr();
    cyc(1'b1, 15'h0060, 64'h600, FULL, 1'b0, '0, "sa_init");
    cyc(1'b1, 15'h0060, 64'h601, FULL, 1'b1, 15'h0060, "sa_old_value");
    cyc(1'b0, '0, '0, '0, 1'b1, 15'h0060, "sa_new_value");
    idle(1);
    cyc(1'b0, '0, '0, '0, 1'b1, 15'h0060, "sa_bank_value");
  endtask

  initial begin
    test_reset();
    test_diff_bank();
    test_conflict_fwd();
    test_partial_mask();
    test_full();
    test_async_reset();
    test_same_addr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
